bench_1_bist: RTL

BENCH_1_BIST -- requirements
Module: bench_1_bist

---
 rtl/bench_1_bist.sv | 92 +++++++++
 1 files changed

// File: rtl/bench_1_bist.sv
// Logic BIST controller: LFSR pattern source for X0/X1 plus an 8-bit MISR
// compacting the latency-delayed response stream into a signature.
module bench_1_bist #(
  parameter int LAT   = 3,
  parameter int SIG_W = 8
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       seed,
  input  logic [7:0]       num_pat,
  input  logic             resp_in,
  output logic             x0_out,
  output logic             x1_out,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature
);

  localparam int CW = (LAT < 2) ? 1 : $clog2(LAT + 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t           state, state_nx;
  logic [7:0]       lfsr;
  logic [7:0]       pcnt;
  logic [CW-1:0]    lcnt;
  logic [CW-1:0]    wcnt;
  logic [SIG_W-1:0] sig;
  logic             launch;
  logic             misr_en;

  always_comb begin
    state_nx = state;
    launch   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          launch   = 1'b1;
          state_nx = (num_pat == 8'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (pcnt == 8'd1) state_nx = (LAT == 0) ? DONE : FLUSH;
      end
      FLUSH: begin
        if (lcnt == CW'(LAT - 1)) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == RUN) || (state == FLUSH);
    done      = (state == DONE);
    x0_out    = (state == RUN) && lfsr[0];
    x1_out    = (state == RUN) && lfsr[1];
    signature = sig;
    // wcnt skips the first LAT busy cycles whose responses belong to no pattern,
    // so exactly num_pat samples are compacted even when num_pat < LAT
    misr_en   = busy && (wcnt == '0);
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state <= IDLE;
      lfsr  <= 8'h01;
      sig   <= '0;
      pcnt  <= '0;
      lcnt  <= '0;
      wcnt  <= '0;
    end else begin
      state <= state_nx;
      if (launch) begin
        lfsr <= (seed == 8'd0) ? 8'h01 : seed;
        sig  <= '0;
        pcnt <= num_pat;
        lcnt <= '0;
        wcnt <= CW'(LAT);
      end else begin
        if (state == RUN) begin
          lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
          pcnt <= pcnt - 8'd1;
        end
        if (state == FLUSH) lcnt <= lcnt + 1'b1;
        if (busy && (wcnt != '0)) wcnt <= wcnt - 1'b1;
        if (misr_en) sig <= {sig[SIG_W-2:0], sig[7] ^ sig[5] ^ sig[4] ^ sig[3] ^ resp_in};
      end
    end
  end

endmodule
